// File: rtl/vol_ctrl_rpt.sv
// Stereo volume/balance controller with hold-to-auto-repeat.
// Takes debounced push-button levels and maintains a master attenuation, a
// signed balance offset and a mute flag. It drives the {left,right}
// attenuation word for the decoder volume register (0 = loudest).
module vol_ctrl_rpt #(
    parameter int              CH_W     = 8,
    parameter logic [CH_W-1:0] ATT_STEP = 8'h10,
    parameter logic [CH_W-1:0] ATT_MAX  = 8'hF0,
    parameter logic [CH_W-1:0] BAL_STEP = 8'h08,
    parameter logic [CH_W-1:0] BAL_MAX  = 8'h40,
    parameter logic [CH_W-1:0] MUTE_VAL = 8'hFE,
    parameter int              HOLD_CYC = 100000,
    parameter int              RPT_CYC  = 25000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              VOL_UP,
    input  logic              VOL_DN,
    input  logic              BAL_L,
    input  logic              BAL_R,
    input  logic              MUTE,
    output logic [2*CH_W-1:0] VOL,
    output logic [CH_W-1:0]   ATT,
    output logic              MUTED,
    output logic              BUSY
);

    localparam int CNT_MAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RPT_LD  = CNT_W'(RPT_CYC - 1);

    // Balance limits in the widened signed domain so the step never wraps.
    localparam logic signed [CH_W:0] BAL_HI = $signed({1'b0, BAL_MAX});
    localparam logic signed [CH_W:0] BAL_LO = -BAL_HI;
    localparam logic signed [CH_W:0] BAL_ST = $signed({1'b0, BAL_STEP});

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT, S_WAIT_REL} state_t;
    typedef enum logic [2:0] {K_NONE, K_MUTE, K_UP, K_DN, K_BL, K_BR} key_t;

    state_t                  state_q, state_d;
    key_t                    key_q, key_d;
    key_t                    act_key;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CH_W-1:0]         att_q, att_d;
    logic signed [CH_W:0]    bal_q, bal_d;
    logic                    muted_q, muted_d;
    logic [2*CH_W-1:0]       vol_q, vol_d;
    logic                    key_lvl;
    logic [CH_W:0]           bal_pos, bal_neg;

    // Louder: subtract one step, floor at zero.
    function automatic logic [CH_W-1:0] att_louder(input logic [CH_W-1:0] a);
        logic signed [CH_W:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, ATT_STEP});
        return diff[CH_W] ? '0 : diff[CH_W-1:0];
    endfunction

    // Quieter: add one step, ceiling at ATT_MAX.
    function automatic logic [CH_W-1:0] att_quieter(input logic [CH_W-1:0] a);
        logic [CH_W:0] sum;
        sum = {1'b0, a} + {1'b0, ATT_STEP};
        return (sum > {1'b0, ATT_MAX}) ? ATT_MAX : sum[CH_W-1:0];
    endfunction

    // Move balance one step left or right, clamped to +/-BAL_MAX.
    function automatic logic signed [CH_W:0] bal_move(input logic signed [CH_W:0] b,
                                                      input logic               to_right);
        logic signed [CH_W:0] nb;
        if (to_right) begin
            nb = b + BAL_ST;
            if (nb > BAL_HI) nb = BAL_HI;
        end else begin
            nb = b - BAL_ST;
            if (nb < BAL_LO) nb = BAL_LO;
        end
        return nb;
    endfunction

    // One channel: master attenuation plus that side's extra, clamped.
    function automatic logic [CH_W-1:0] chan_att(input logic [CH_W-1:0] a,
                                                 input logic [CH_W:0]   extra);
        logic [CH_W:0] sum;
        sum = {1'b0, a} + extra;
        return (sum > {1'b0, ATT_MAX}) ? ATT_MAX : sum[CH_W-1:0];
    endfunction

    // Level of whichever key is currently latched.
    always_comb begin
        key_lvl = 1'b0;
        case (key_q)
            K_MUTE:  key_lvl = MUTE;
            K_UP:    key_lvl = VOL_UP;
            K_DN:    key_lvl = VOL_DN;
            K_BL:    key_lvl = BAL_L;
            K_BR:    key_lvl = BAL_R;
            default: key_lvl = 1'b0;
        endcase
    end

    // Next-state: key arbitration, hold/repeat timing, actions and channel mapping.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        att_d   = att_q;
        bal_d   = bal_q;
        muted_d = muted_q;
        act_key = K_NONE;

        case (state_q)
            S_IDLE: begin
                if (MUTE)        key_d = K_MUTE;
                else if (VOL_UP) key_d = K_UP;
                else if (VOL_DN) key_d = K_DN;
                else if (BAL_L)  key_d = K_BL;
                else if (BAL_R)  key_d = K_BR;
                else             key_d = K_NONE;
                if (key_d != K_NONE) begin
                    act_key = key_d;
                    cnt_d   = HOLD_LD;
                    state_d = (key_d == K_MUTE) ? S_WAIT_REL : S_HOLD;
                end
            end
            S_HOLD, S_REPEAT: begin
                if (!key_lvl) begin
                    state_d = S_IDLE;
                    key_d   = K_NONE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    act_key = key_q;
                    cnt_d   = RPT_LD;
                    state_d = S_REPEAT;
                end
            end
            S_WAIT_REL: begin
                if (!MUTE) begin
                    state_d = S_IDLE;
                    key_d   = K_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                key_d   = K_NONE;
            end
        endcase

        case (act_key)
            K_MUTE: muted_d = ~muted_q;
            K_UP: begin
                att_d   = att_louder(att_q);
                muted_d = 1'b0;
            end
            K_DN: begin
                att_d   = att_quieter(att_q);
                muted_d = 1'b0;
            end
            K_BL:    bal_d = bal_move(bal_q, 1'b0);
            K_BR:    bal_d = bal_move(bal_q, 1'b1);
            default: ;
        endcase

        // Positive balance attenuates the left side, negative the right.
        bal_pos = bal_q[CH_W] ? '0 : $unsigned(bal_q);
        bal_neg = bal_q[CH_W] ? $unsigned(-bal_q) : '0;
        if (muted_q) vol_d = {MUTE_VAL, MUTE_VAL};
        else         vol_d = {chan_att(att_q, bal_pos), chan_att(att_q, bal_neg)};
    end

    // State and output registers; reset wins over every key.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            key_q   <= K_NONE;
            cnt_q   <= '0;
            att_q   <= '0;
            bal_q   <= '0;
            muted_q <= 1'b0;
            vol_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            att_q   <= att_d;
            bal_q   <= bal_d;
            muted_q <= muted_d;
            vol_q   <= vol_d;
        end
    end

    assign VOL   = vol_q;
    assign ATT   = att_q;
    assign MUTED = muted_q;
    assign BUSY  = (state_q != S_IDLE);

endmodule

// File: tb/tb_vol_ctrl_rpt.sv
// Bench for vol_ctrl_rpt with short hold/repeat intervals.
// Reference model tracks press age: an action fires at age 0, and at
// HOLD + k*RPT while the same key stays held (MUTE fires only at age 0).
module tb_vol_ctrl_rpt;

    localparam int HOLD = 10;
    localparam int RPT  = 4;

    logic        clk;
    logic        rst;
    logic [4:0]  keys;   // 0 MUTE, 1 VOL_UP, 2 VOL_DN, 3 BAL_L, 4 BAL_R (priority order)
    logic [15:0] vol;
    logic [7:0]  att;
    logic        muted;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_att    = 0;
    int          m_bal    = 0;
    logic        m_muted  = 1'b0;
    int          m_active = -1;
    int          m_age    = 0;
    logic [15:0] m_vol    = 16'h0000;

    vol_ctrl_rpt #(
        .CH_W(8), .ATT_STEP(8'h10), .ATT_MAX(8'hF0), .BAL_STEP(8'h08),
        .BAL_MAX(8'h40), .MUTE_VAL(8'hFE), .HOLD_CYC(HOLD), .RPT_CYC(RPT)
    ) dut (
        .CLK(clk), .RST(rst),
        .VOL_UP(keys[1]), .VOL_DN(keys[2]), .BAL_L(keys[3]), .BAL_R(keys[4]),
        .MUTE(keys[0]),
        .VOL(vol), .ATT(att), .MUTED(muted), .BUSY(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_vol();
        int l, r;
        if (m_muted) return 16'hFEFE;
        l = m_att + ((m_bal > 0) ? m_bal : 0);
        r = m_att + ((m_bal < 0) ? -m_bal : 0);
        if (l > 240) l = 240;
        if (r > 240) r = 240;
        return {8'(l), 8'(r)};
    endfunction

    task automatic model_action(input int k);
        case (k)
            0: m_muted = ~m_muted;
            1: begin m_att = (m_att - 16 < 0) ? 0 : m_att - 16; m_muted = 1'b0; end
            2: begin m_att = (m_att + 16 > 240) ? 240 : m_att + 16; m_muted = 1'b0; end
            3: m_bal = (m_bal - 8 < -64) ? -64 : m_bal - 8;
            4: m_bal = (m_bal + 8 > 64) ? 64 : m_bal + 8;
            default: ;
        endcase
    endtask

    task automatic model_step();
        logic [15:0] nv;
        int pick;
        if (rst) begin
            m_att = 0; m_bal = 0; m_muted = 1'b0; m_active = -1; m_age = 0; m_vol = 16'h0000;
        end else begin
            nv = model_vol();
            if (m_active < 0) begin
                pick = -1;
                for (int k = 0; k < 5; k++) if (keys[k] && pick < 0) pick = k;
                if (pick >= 0) begin
                    model_action(pick);
                    m_active = pick;
                    m_age = 0;
                end
            end else if (!keys[m_active]) begin
                m_active = -1;
            end else begin
                m_age++;
                if (m_active != 0 && m_age >= HOLD && ((m_age - HOLD) % RPT) == 0)
                    model_action(m_active);
            end
            m_vol = nv;
        end
    endtask

    // Advance one edge, update the model with the sampled inputs, settle.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic press(input int k, input int n);
        keys = 5'(1 << k);
        repeat (n) tick();
        keys = '0;
        tick();
    endtask

    task automatic do_reset();
        keys = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        keys = 5'b11111;
        tick();
        tick();
        if ({vol, att, muted, busy} !== 26'h0) begin
            failures++;
            $display("FAIL reset_outputs got vol=%h att=%h muted=%b busy=%b want all zero", vol, att, muted, busy);
        end
        checks++;
        keys = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_pulse();
        do_reset();
        keys = 5'b00100;
        tick();
        if ({att, vol, busy} !== {8'h10, 16'h0000, 1'b1}) begin
            failures++;
            $display("FAIL pulse_edge got att=%h vol=%h busy=%b want att=10 vol=0000 busy=1", att, vol, busy);
        end
        checks++;
        keys = '0;
        tick();
        if ({att, vol, busy} !== {8'h10, 16'h1010, 1'b0}) begin
            failures++;
            $display("FAIL pulse_release got att=%h vol=%h busy=%b want att=10 vol=1010 busy=0", att, vol, busy);
        end
        checks++;
    endtask

    task automatic test_hold_repeat();
        do_reset();
        keys = 5'b00100;
        repeat (30) tick();
        if ({att, vol} !== {8'h60, 16'h6060}) begin
            failures++;
            $display("FAIL hold_30 got att=%h vol=%h want att=60 vol=6060", att, vol);
        end
        checks++;
        repeat (40) tick();
        if ({att, vol, busy} !== {8'hF0, 16'hF0F0, 1'b1}) begin
            failures++;
            $display("FAIL hold_sat got att=%h vol=%h busy=%b want att=f0 vol=f0f0 busy=1", att, vol, busy);
        end
        checks++;
        keys = '0;
        tick();
        if ({vol, att, muted, busy} !== {m_vol, 8'(m_att), m_muted, m_active >= 0}) begin
            failures++;
            $display("FAIL hold_model got vol=%h att=%h want vol=%h att=%h", vol, att, m_vol, 8'(m_att));
        end
        checks++;
    endtask

    task automatic test_balance();
        do_reset();
        repeat (2) press(2, 1);
        repeat (3) press(4, 1);
        if (vol !== 16'h3820) begin
            failures++;
            $display("FAIL bal_r3 got vol=%h want 3820", vol);
        end
        checks++;
        press(4, 40);
        if (vol !== 16'h6020) begin
            failures++;
            $display("FAIL bal_r_clamp got vol=%h want 6020", vol);
        end
        checks++;
        repeat (16) press(3, 1);
        if ({vol, att} !== {16'h2060, 8'h20}) begin
            failures++;
            $display("FAIL bal_l16 got vol=%h att=%h want vol=2060 att=20", vol, att);
        end
        checks++;
    endtask

    task automatic test_mute();
        do_reset();
        repeat (3) press(2, 1);
        keys = 5'b00001;
        tick();
        if ({muted, busy} !== 2'b11) begin
            failures++;
            $display("FAIL mute_toggle got muted=%b busy=%b want 1 1", muted, busy);
        end
        checks++;
        repeat (49) tick();
        keys = '0;
        tick();
        if ({muted, vol, busy} !== {1'b1, 16'hFEFE, 1'b0}) begin
            failures++;
            $display("FAIL mute_hold got muted=%b vol=%h busy=%b want 1 fefe 0", muted, vol, busy);
        end
        checks++;
        press(3, 1);
        if ({muted, vol} !== {1'b1, 16'hFEFE}) begin
            failures++;
            $display("FAIL mute_bal got muted=%b vol=%h want 1 fefe", muted, vol);
        end
        checks++;
        press(1, 1);
        if ({muted, att, vol} !== {1'b0, 8'h20, 16'h2028}) begin
            failures++;
            $display("FAIL mute_volup got muted=%b att=%h vol=%h want 0 20 2028", muted, att, vol);
        end
        checks++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        repeat (4) press(2, 1);
        keys = 5'b00110;
        tick();
        if (att !== 8'h30) begin
            failures++;
            $display("FAIL simul_first got att=%h want 30", att);
        end
        checks++;
        repeat (4) tick();
        keys = 5'b00100;
        tick();
        if ({att, busy} !== {8'h30, 1'b0}) begin
            failures++;
            $display("FAIL simul_release got att=%h busy=%b want 30 0", att, busy);
        end
        checks++;
        tick();
        if ({att, busy} !== {8'h40, 1'b1}) begin
            failures++;
            $display("FAIL simul_repress got att=%h busy=%b want 40 1", att, busy);
        end
        checks++;
        keys = '0;
        tick();
    endtask

    task automatic test_reset_mid_repeat();
        do_reset();
        keys = 5'b00100;
        repeat (16) tick();
        rst = 1'b1;
        tick();
        tick();
        if ({vol, att, muted, busy} !== 26'h0) begin
            failures++;
            $display("FAIL rst_mid got vol=%h att=%h muted=%b busy=%b want all zero", vol, att, muted, busy);
        end
        checks++;
        rst = 1'b0;
        tick();
        if ({att, busy} !== {8'h10, 1'b1}) begin
            failures++;
            $display("FAIL rst_repress got att=%h busy=%b want 10 1", att, busy);
        end
        checks++;
        repeat (9) tick();
        if (att !== 8'h10) begin
            failures++;
            $display("FAIL rst_before_rpt got att=%h want 10", att);
        end
        checks++;
        tick();
        if (att !== 8'h20) begin
            failures++;
            $display("FAIL rst_first_rpt got att=%h want 20", att);
        end
        checks++;
        keys = '0;
        tick();
    endtask

    task automatic test_random();
        int len;
        do_reset();
        for (int n = 0; n < 90; n++) begin
            if ($urandom_range(0, 2) == 0) keys = 5'($urandom_range(0, 31));
            else                           keys = 5'(1 << $urandom_range(0, 4));
            rst = ($urandom_range(0, 29) == 0);
            len = $urandom_range(1, 26);
            for (int c = 0; c < len; c++) begin
                tick();
                rst = 1'b0;
                if ({vol, att, muted, busy} !== {m_vol, 8'(m_att), m_muted, m_active >= 0}) begin
                    failures++;
                    $display("FAIL random_model got vol=%h att=%h muted=%b busy=%b want vol=%h att=%h muted=%b busy=%b",
                             vol, att, muted, busy, m_vol, 8'(m_att), m_muted, m_active >= 0);
                end
                checks++;
            end
            keys = '0;
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        rst  = 1'b1;
        keys = '0;
        test_reset();
        test_pulse();
        test_hold_repeat();
        test_balance();
        test_mute();
        test_simultaneous();
        test_reset_mid_repeat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
